serial_deframer: RTL

- Downstream consumer of the single-bit sampling flop stage.
- Takes the registered serial bit stream, one bit per `c` cycle, and detects UART-style frames: start bit 0, DATA_W data bits LSB-first, optional parity bit, stop bit 1.
- Presents each good word on a one-entry valid/ready output buffer to the parallel-side logic.
- Flags framing, parity and overflow errors.

---
 rtl/serial_deframer_pkg.sv | 17 +
 rtl/serial_deframer_if.sv | 25 ++
 rtl/serial_deframer_sipo.sv | 24 ++
 rtl/serial_deframer.sv | 114 +++++++++++
 4 files changed

// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: shared state encoding, default word width and line levels
// for the serial deframer slice.
package serial_deframer_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/serial_deframer_if.sv
// serial_deframer_if: serial input, valid/ready word output and status flags.
// master = deframer side, slave = line driver / parallel consumer side.
interface serial_deframer_if
  import serial_deframer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              d;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              frame_err;
  logic              overflow;
  logic              busy;

  modport master (
    input  d, out_ready,
    output out_data, out_valid, frame_err, overflow, busy
  );

  modport slave (
    output d, out_ready,
    input  out_data, out_valid, frame_err, overflow, busy
  );
endinterface

// File: rtl/serial_deframer_sipo.sv
// sipo_shift: serial-in/parallel-out register, new bits enter at the MSB so the
// first bit of a W-bit burst ends up at bit 0. par is the XOR of the held word.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic         rst,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q,
  output logic         par
);

  // right shift on enable, cleared by reset
  always_ff @(posedge c) begin
    if (rst)     q <= '0;
    else if (en) q <= {d, q[W-1:1]};
  end

  // after a full burst the register holds exactly the frame bits, so its
  // reduction XOR is the running parity of the word
  assign par = ^q;

endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: UART-style frame detector (start 0, DATA_W bits LSB first,
// optional even parity, stop 1) feeding a one-entry valid/ready buffer.
// Optional feature macro: SERIAL_DEFRAMER_PARITY_EN (adds the PARITY state).
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 4
) (
  input  logic                  c,
  input  logic                  rst,
  serial_deframer_if.master     bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t              state, nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   word;
  logic                word_par;
  logic                shift_en, stop_ev, good, bad, par_err;

  sipo_shift #(.W(DATA_W)) u_sipo (
    .c   (c),
    .rst (rst),
    .en  (shift_en),
    .d   (bus.d),
    .q   (word),
    .par (word_par)
  );

`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic par_bit;

  // capture the received parity bit
  always_ff @(posedge c) begin
    if (rst)                 par_bit <= 1'b0;
    else if (state == PARITY) par_bit <= bus.d;
  end

  assign par_err = word_par ^ par_bit;
`else
  logic unused_par;
  assign unused_par = word_par;
  assign par_err    = 1'b0;
`endif

  // state register
  always_ff @(posedge c) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.d == START_BIT) nxt = DATA;
      DATA: if (cnt == LAST) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
        nxt = PARITY;
`else
        nxt = STOP;
`endif
      end
`ifdef SERIAL_DEFRAMER_PARITY_EN
      PARITY: nxt = STOP;
`endif
      STOP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // per-state strobes; good/bad are only meaningful on the stop edge
  always_comb begin
    shift_en = (state == DATA);
    stop_ev  = (state == STOP);
    good     = stop_ev && (bus.d == STOP_BIT) && !par_err;
    bad      = stop_ev && !good;
    bus.busy = (state != IDLE);
  end

  // data-bit counter: cleared on the start bit, counts DATA edges
  always_ff @(posedge c) begin
    if (rst)                                     cnt <= '0;
    else if (state == IDLE && bus.d == START_BIT) cnt <= '0;
    else if (state == DATA)                      cnt <= cnt + CNT_W'(1);
  end

  // one-cycle error pulse following a bad stop edge
  always_ff @(posedge c) begin
    if (rst) bus.frame_err <= 1'b0;
    else     bus.frame_err <= bad;
  end

  // output buffer: load on good frame when free or draining this edge,
  // otherwise drop the word and latch overflow
  always_ff @(posedge c) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      if (good && (!bus.out_valid || bus.out_ready)) begin
        bus.out_data  <= word;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (good && bus.out_valid && !bus.out_ready) bus.overflow <= 1'b1;
    end
  end

endmodule
